conv8_psum_accum: RTL and testbench

//  Downstream stage of the 8-pixel stride-2 conv core. Takes its four 2*DW-bit row partial

---
 rtl/conv8_psum_accum.sv | 190 +++++++++++++++++++
 tb/tb_conv8_psum_accum.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv8_psum_accum.sv
// Accumulates four signed row partial sums over a tile of passes, then bias, round, shift, ReLU, saturate.
// Latency: final beat accepted at edge N -> out_valid high after edge N; 1 beat/cycle sustained.
// Backpressure: in_ready = ~out_valid | out_ready; a held result stalls every beat, ACC beats included.
module conv8_psum_accum #(
    parameter int DW    = 8,
    parameter int ACC_W = 24,
    parameter int NP_W  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clr,
    input  logic [NP_W-1:0]      cfg_npass,
    input  logic [4:0]           cfg_shift,
    input  logic                 cfg_relu,
    input  logic [4*ACC_W-1:0]   cfg_bias,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*DW-1:0]      in_sum1,
    input  logic [2*DW-1:0]      in_sum2,
    input  logic [2*DW-1:0]      in_sum3,
    input  logic [2*DW-1:0]      in_sum4,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_act1,
    output logic [DW-1:0]        out_act2,
    output logic [DW-1:0]        out_act3,
    output logic [DW-1:0]        out_act4,
    output logic                 busy
);

    typedef enum logic {S_IDLE, S_ACC} state_t;

    localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACT_MIN = ~ACT_MAX;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NP_W-1:0]          r_pass_cnt;
    logic [NP_W-1:0]          r_npass;
    logic [4:0]               r_shift;
    logic                     r_relu;
    logic signed [ACC_W-1:0]  r_acc [4];
    logic                     r_out_vld;
    logic signed [DW-1:0]     r_act [4];

    logic                     w_fire;
    logic                     w_final;
    logic [NP_W-1:0]          w_npass_new;
    logic [4:0]               w_shift;
    logic                     w_relu;
    logic signed [2*DW-1:0]   w_sum  [4];
    logic signed [ACC_W-1:0]  w_base [4];
    logic signed [ACC_W-1:0]  w_bias [4];
    logic signed [ACC_W-1:0]  w_part [4];
    logic signed [DW-1:0]     w_act  [4];

    // Round half up, arithmetic shift, optional ReLU, saturate to DW bits.
    function automatic logic signed [DW-1:0] requant(
        input logic signed [ACC_W-1:0] t,
        input logic [4:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] r;
        half = '0;
        if (sh != 5'd0) begin
            half = ACC_W'(1) << (sh - 5'd1);
        end
        r = (t + half) >>> sh;
        if (relu && (r < 0)) begin
            r = '0;
        end
        if (r > ACT_MAX) begin
            r = ACT_MAX;
        end else if (r < ACT_MIN) begin
            r = ACT_MIN;
        end
        return r[DW-1:0];
    endfunction

    assign in_ready = ~r_out_vld | out_ready;
    assign w_fire   = in_valid & in_ready & ~clr;
    assign busy     = (r_pass_cnt != '0);

    assign w_sum[0] = in_sum1;
    assign w_sum[1] = in_sum2;
    assign w_sum[2] = in_sum3;
    assign w_sum[3] = in_sum4;

    // Config in force for this beat: live inputs on the first beat of a tile, latched copy afterwards.
    always_comb begin
        w_npass_new = (cfg_npass == '0) ? NP_W'(1) : cfg_npass;
        w_shift     = r_shift;
        w_relu      = r_relu;
        w_final     = (r_pass_cnt == NP_W'(r_npass - NP_W'(1)));
        if (r_state == S_IDLE) begin
            w_shift = cfg_shift;
            w_relu  = cfg_relu;
            w_final = (w_npass_new == NP_W'(1));
        end
    end

    // Per-lane running sum, final sum with bias, and requantised activation.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_base[i] = (r_state == S_IDLE) ? '0 : r_acc[i];
            w_bias[i] = cfg_bias[i*ACC_W +: ACC_W];
            w_part[i] = w_base[i] + ACC_W'(w_sum[i]);
            w_act[i]  = requant(w_part[i] + w_bias[i], w_shift, w_relu);
        end
    end

    // Tile state: idle until a non-final beat starts a tile, back to idle on final beat or clr.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else if (w_fire) begin
            w_state_nxt = w_final ? S_IDLE : S_ACC;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pass counter, latched tile config and accumulators.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pass_cnt <= '0;
            r_npass    <= NP_W'(1);
            r_shift    <= 5'd0;
            r_relu     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
            end
        end else if (clr) begin
            r_pass_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_fire) begin
            if (r_state == S_IDLE) begin
                r_npass <= w_npass_new;
                r_shift <= cfg_shift;
                r_relu  <= cfg_relu;
            end
            if (w_final) begin
                r_pass_cnt <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_acc[i] <= '0;
                end
            end else begin
                r_pass_cnt <= r_pass_cnt + NP_W'(1);
                for (int i = 0; i < 4; i++) begin
                    r_acc[i] <= w_part[i];
                end
            end
        end
    end

    // One-deep output register: load on final beat, clear on handshake, hold otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_vld <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_act[i] <= '0;
            end
        end else if (w_fire && w_final) begin
            r_out_vld <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                r_act[i] <= w_act[i];
            end
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign out_valid = r_out_vld;
    assign out_act1  = r_act[0];
    assign out_act2  = r_act[1];
    assign out_act3  = r_act[2];
    assign out_act4  = r_act[3];

endmodule

// File: tb/tb_conv8_psum_accum.sv
// Bench for conv8_psum_accum: directed tiles checked by a tile-level model and literal expectations.
// Inputs change 1 time unit after the rising edge; everything is observed on the falling edge.
// A watchdog ends the run if the sequence ever stalls.
module tb_conv8_psum_accum;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int NP_W  = 8;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic                       clr;
    logic [NP_W-1:0]            cfg_npass;
    logic [4:0]                 cfg_shift;
    logic                       cfg_relu;
    logic [4*ACC_W-1:0]         cfg_bias;
    logic                       in_valid;
    logic                       in_ready;
    logic signed [2*DW-1:0]     in_sum1, in_sum2, in_sum3, in_sum4;
    logic                       out_valid;
    logic                       out_ready;
    logic signed [DW-1:0]       out_act1, out_act2, out_act3, out_act4;
    logic                       busy;

    int total = 0;
    int bad   = 0;

    conv8_psum_accum #(.DW(DW), .ACC_W(ACC_W), .NP_W(NP_W)) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .cfg_npass(cfg_npass), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_bias(cfg_bias),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum1(in_sum1), .in_sum2(in_sum2), .in_sum3(in_sum3), .in_sum4(in_sum4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_act1(out_act1), .out_act2(out_act2), .out_act3(out_act3), .out_act4(out_act4),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- tile-level reference model ----------------
    typedef struct { longint a[4]; } res_t;
    res_t   exp_q[$];
    int     m_cnt = 0;
    int     m_np  = 1;
    int     m_sh  = 0;
    bit     m_relu = 1'b0;
    longint m_acc[4] = '{0, 0, 0, 0};

    function automatic longint wrap(input longint v);
        longint m;
        m = v & ((longint'(1) << ACC_W) - 1);
        if (m >= (longint'(1) << (ACC_W - 1))) m = m - (longint'(1) << ACC_W);
        return m;
    endfunction

    function automatic longint quant(input longint t, input int sh, input bit relu);
        longint r;
        r = t;
        if (sh > 0) r = wrap(t + (longint'(1) << (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Compare every cycle against the model, then advance the model by this cycle's handshakes.
    always @(negedge clk) begin
        longint s[4];
        longint b;
        res_t   r;
        s[0] = in_sum1; s[1] = in_sum2; s[2] = in_sum3; s[3] = in_sum4;
        if (!rstn) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_act", {out_act1, out_act2, out_act3, out_act4}, 0);
            exp_q.delete();
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_acc[i] = 0;
        end else begin
            chk("in_ready", in_ready, (exp_q.size() == 0 || out_ready) ? 1 : 0);
            chk("busy", busy, (m_cnt != 0) ? 1 : 0);
            chk("out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
            if (exp_q.size() != 0) begin
                chk("model_act1", out_act1, exp_q[0].a[0]);
                chk("model_act2", out_act2, exp_q[0].a[1]);
                chk("model_act3", out_act3, exp_q[0].a[2]);
                chk("model_act4", out_act4, exp_q[0].a[3]);
                if (out_ready) void'(exp_q.pop_front());
            end
            if (clr) begin
                m_cnt = 0;
                for (int i = 0; i < 4; i++) m_acc[i] = 0;
            end else if (in_valid && (exp_q.size() == 0 || out_ready)) begin
                if (m_cnt == 0) begin
                    m_np   = (cfg_npass == 0) ? 1 : int'(cfg_npass);
                    m_sh   = int'(cfg_shift);
                    m_relu = cfg_relu;
                end
                if (m_cnt == m_np - 1) begin
                    for (int i = 0; i < 4; i++) begin
                        b = longint'($signed(cfg_bias[i*ACC_W +: ACC_W]));
                        r.a[i] = quant(wrap(m_acc[i] + s[i] + b), m_sh, m_relu);
                        m_acc[i] = 0;
                    end
                    exp_q.push_back(r);
                    m_cnt = 0;
                end else begin
                    for (int i = 0; i < 4; i++) m_acc[i] = m_acc[i] + s[i];
                    m_cnt++;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sums(input int a, input int b, input int c, input int d);
        in_sum1 = 16'(a); in_sum2 = 16'(b); in_sum3 = 16'(c); in_sum4 = 16'(d);
    endtask

    task automatic set_bias(input int a, input int b, input int c, input int d);
        cfg_bias = {24'(d), 24'(c), 24'(b), 24'(a)};
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic beat(input int a, input int b, input int c, input int d);
        int n;
        set_sums(a, b, c, d);
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                chk("beat_timeout", 0, 1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Result must be valid at the first observation after the final beat.
    task automatic expect_out(input string nm, input int a, input int b, input int c, input int d);
        @(negedge clk);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_act1"}, out_act1, a);
        chk({nm, "_act2"}, out_act2, b);
        chk({nm, "_act3"}, out_act3, c);
        chk({nm, "_act4"}, out_act4, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_npass = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
        set_bias(0, 0, 0, 0);
        set_sums(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        tick();
        rstn = 1'b1;
        tick();

        // single-pass tile with saturation
        beat(5, -3, 127, 200);
        expect_out("t1", 5, -3, 127, 127);

        // npass=0 behaves as 1; negative saturation, bias on one lane
        cfg_npass = 8'd0;
        set_bias(0, 0, 10, 0);
        beat(-200, 300, 0, -128);
        expect_out("t1b", -128, 127, 10, -128);

        // three passes, bias 4, shift 2; mid-tile cfg change must be ignored
        cfg_npass = 8'd3; cfg_shift = 5'd2;
        set_bias(4, 4, 4, 4);
        beat(100, 100, 100, -100);
        cfg_npass = 8'd1; cfg_shift = 5'd0;
        beat(100, 100, 100, -100);
        beat(100, 100, 100, -100);
        expect_out("t2", 76, 76, 76, -74);

        // ReLU on/off over a two-pass tile
        set_bias(0, 0, 0, 0);
        cfg_npass = 8'd2; cfg_shift = 5'd0; cfg_relu = 1'b1;
        beat(-50, 10, -1, 0);
        beat(-50, 10, -1, 0);
        expect_out("t3_relu", 0, 20, 0, 0);
        cfg_relu = 1'b0;
        beat(-50, 10, -1, 0);
        beat(-50, 10, -1, 0);
        expect_out("t3_norelu", -100, 20, -2, 0);

        // back-to-back single-pass tiles at one beat per cycle
        cfg_npass = 8'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_sums(k * 10, -k, k * 40, 3 - k);
            tick();
        end
        in_valid = 1'b0;
        tick();

        // backpressure: held result stalls the next beat, released on out_ready
        out_ready = 1'b0;
        beat(1, 2, 3, 4);
        expect_out("t4_held", 1, 2, 3, 4);
        set_sums(7, 8, 9, 10);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_rdy", in_ready, 0);
            chk("t4_stall_vld", out_valid, 1);
            chk("t4_stall_act1", out_act1, 1);
            chk("t4_stall_act4", out_act4, 4);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        expect_out("t4_next", 7, 8, 9, 10);

        // clr after 2 of 3 passes, discarded beat, then a clean tile of ones
        cfg_npass = 8'd3;
        beat(50, 50, 50, 50);
        beat(50, 50, 50, 50);
        @(negedge clk);
        chk("t5_busy_before", busy, 1);
        tick();
        clr = 1'b1; in_valid = 1'b1; set_sums(9, 9, 9, 9);
        @(negedge clk);
        chk("t5_clr_rdy", in_ready, 1);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy_after", busy, 0);
        tick();
        beat(1, 1, 1, 1);
        beat(1, 1, 1, 1);
        beat(1, 1, 1, 1);
        expect_out("t5", 3, 3, 3, 3);

        // reset mid-tile
        beat(20, 20, 20, 20);
        @(negedge clk);
        chk("t6_busy_mid", busy, 1);
        tick();
        rstn = 1'b0;
        #1;
        chk("t6_async_busy", busy, 0);
        tick();
        rstn = 1'b1;
        tick();

        // reset with a pending result
        out_ready = 1'b0; cfg_npass = 8'd1;
        beat(33, 34, 35, 36);
        expect_out("t6_pending", 33, 34, 35, 36);
        rstn = 1'b0;
        #1;
        chk("t6_async_vld", out_valid, 0);
        chk("t6_async_act", {out_act1, out_act2, out_act3, out_act4}, 0);
        tick();
        rstn = 1'b1; out_ready = 1'b1;
        tick();

        // post-reset tile: npass=2, shift=1, negative rounding on lane 4
        cfg_npass = 8'd2; cfg_shift = 5'd1;
        beat(10, 20, 30, -3);
        beat(10, 20, 30, -3);
        expect_out("t6_post", 10, 20, 30, -3);

        repeat (3) tick();
        chk("drain_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
